just_pass_arbiter: RTL and testbench
====================================

// Module: just_pass_arbiter
// PURPOSE
//  Shares one Just_Pass datapath (RTL or SystemC-wrapped) between N_REQ requesters. Round-robin
//  grants one request per cycle, tracks in-flight tags over the fixed datapath latency, and routes
//  each data_o/bool_o result back to its issuer. Also sequences the datapath reset, warm-up and flush.
// PARAMETERS
//  DATA_WIDTH   8  width of data_i/data_o on requesters and datapath
//  N_REQ        4  number of requesters (>=2)
//  DP_LATENCY   1  cycles from dp_data_o sampled to dp_data_i/dp_bool_i valid (>=1)
//  RST_CYCLES   4  cycles dp_rstn held low per datapath reset sequence (>=1)
// PORTS
//  clk        in   1               clock, all logic on posedge
//  rstn       in   1               async active-low reset
//  req_valid  in   N_REQ           per-requester request valid
//  req_data   in   N_REQ*DATA_WIDTH packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready  out  N_REQ           one-hot grant; transfer when req_valid[i] & req_ready[i]
//  rsp_valid  out  N_REQ           one-hot response strobe, 1 cycle, no backpressure
//  rsp_data   out  DATA_WIDTH      datapath data_o for the strobed requester
//  rsp_bool   out  1               datapath bool_o for the strobed requester
//  flush_i    in   1               pulse: drain, then re-reset datapath
//  busy_o     out  1               high unless state RUN with no tag in flight
//  dp_rstn    out  1               datapath reset, active low
//  dp_data_o  out  DATA_WIDTH      datapath data_i
//  dp_data_i  in   DATA_WIDTH      datapath data_o
//  dp_bool_i  in   1               datapath bool_o
// BEHAVIOUR
//  Reset (rstn=0): state=DPRST, counter=0, rr pointer=0, all tags invalid; req_ready=0, rsp_valid=0,
//   rsp_data=0, rsp_bool=0, dp_rstn=0, dp_data_o=0, busy_o=1.
//  FSM: DPRST: dp_rstn=0 for RST_CYCLES cycles -> WARM. WARM: dp_rstn=1, no grants, DP_LATENCY
//   cycles -> RUN. RUN: grants enabled; flush_i=1 -> DRAIN. DRAIN: no grants; when all tags invalid
//   -> DPRST. flush_i ignored outside RUN. req_ready=0 in every state except RUN.
//  Arbitration (RUN only): among asserted req_valid, grant first index >= pointer, wrapping N_REQ-1->0.
//   Pointer <= granted+1 (mod N_REQ) on grant only; unchanged on idle cycles. Grant is combinational
//   from req_valid (same-cycle ready); at most one grant per cycle.
//  Issue: on grant, dp_data_o <= req_data[granted] (registered, 1 cycle); no grant -> dp_data_o <= 0.
//  Tag pipe: DP_LATENCY+1 stages of {valid, id}; stage 0 written on grant, shifts every cycle.
//  Return: final-stage valid -> rsp_valid[id]=1, rsp_data=dp_data_i, rsp_bool=dp_bool_i, same cycle.
//   Total: handshake in cycle t -> rsp_valid in cycle t+1+DP_LATENCY. rsp_data/bool=0 when no strobe.
//  Ordering: responses return in grant order; throughput one request/cycle sustained.
//  Boundaries: all N_REQ valid every cycle -> strict rotation 0,1,..,N_REQ-1,0; single requester ->
//   granted every cycle; flush with tags in flight -> those responses still delivered before DPRST;
//   rstn mid-operation -> in-flight tags discarded, no rsp_valid emitted, sequence restarts at DPRST.
//  Widths: ID_W=$clog2(N_REQ); pointer and ids ID_W bits; wrap compares against N_REQ-1 explicitly.
// STRUCTURE
//  Package just_pass_pkg: DATA_WIDTH default, state_e {DPRST,WARM,RUN,DRAIN}, tag_t struct {valid,id}.
//  Sub-module rr_arbiter #(N_REQ): req vector + pointer in, one-hot grant + index out, pointer reg.
//  Top holds FSM, cycle counter ($clog2(max(RST_CYCLES,DP_LATENCY))+1 bits), tag pipe, issue regs.
// TESTING
//  1 reset release: dp_rstn low exactly 4 cycles, req_ready=0 for further DP_LATENCY cycles, then RUN.
//  2 single req: req 2 data 8'hA5 at t -> rsp_valid=4'b0100, rsp_data=8'hA5 (pass) at t+2, DP_LATENCY=1.
//  3 all four valid 12 cycles -> grants 0,1,2,3 x3; each requester gets 3 responses in grant order.
//  4 idle gap: grant req 1, 5 idle cycles, req 0 and 3 valid -> req 3 granted first (pointer=2).
//  5 flush with 2 tags in flight -> both rsp delivered, then dp_rstn low 4 cycles, busy_o high throughout.
//  6 rstn low mid-burst -> all outputs at reset values asynchronously; no stray rsp_valid after release.
//  Bench runs RTL and SystemC Just_Pass side by side; rsp streams must match cycle-for-cycle.

Source files
------------

// File: rtl/just_pass_pkg.sv
// Shared types for the Just_Pass arbiter slice.
// Holds the controller state encoding and the in-flight tag record.
package just_pass_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int TAG_ID_W       = 4;

  typedef enum logic [1:0] {
    DPRST = 2'd0,
    WARM  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/just_pass_arbiter_if.sv
// Requester-side bundle: request handshake plus response strobe.
// The arbiter takes the slave view, requesters the master view.
interface just_pass_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_data;
  logic                        rsp_bool;

  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_bool
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_bool
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer.
// Pointer moves past the winner only when something is granted.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_any
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr_q;
    gnt_any = 1'b0;
    cand    = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
      cand = (cand == LAST) ? '0 : cand + 1'b1;
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any)
      ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/just_pass_arbiter.sv
// Shares one Just_Pass datapath between N_REQ requesters and routes
// each result back to its issuer; also sequences datapath reset/flush.
module just_pass_arbiter
  import just_pass_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_REQ      = 4,
  parameter int DP_LATENCY = 1,
  parameter int RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  just_pass_arbiter_if.slave    bus,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  dp_rstn,
  output logic [DATA_WIDTH-1:0] dp_data_o,
  input  logic [DATA_WIDTH-1:0] dp_data_i,
  input  logic                  dp_bool_i
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int MAX_C = (RST_CYCLES > DP_LATENCY) ? RST_CYCLES : DP_LATENCY;
  localparam int CNT_W = $clog2(MAX_C) + 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  tag_t [DP_LATENCY:0]     tag_q, tag_d;
  logic [DATA_WIDTH-1:0]   dp_data_q, dp_data_d;

  logic                    run;
  logic [N_REQ-1:0]        gnt;
  logic [ID_W-1:0]         gnt_idx;
  logic                    gnt_any;
  logic                    any_tag;
  tag_t                    last;
  logic [N_REQ-1:0]        rsp_valid;

  assign run = (state_q == RUN);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk     (clk),
    .rstn    (rstn),
    .req     (bus.req_valid & {N_REQ{run}}),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    any_tag = 1'b0;
    for (int k = 0; k <= DP_LATENCY; k++)
      any_tag = any_tag | tag_q[k].valid;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DPRST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = WARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WARM: begin
        if (cnt_q == CNT_W'(DP_LATENCY - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (flush_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!any_tag) begin
          state_d = DPRST;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = DPRST;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage 0 lines up with dp_data_o; the last stage with dp_data_i.
  always_comb begin
    tag_d          = tag_q;
    tag_d[0].valid = gnt_any;
    tag_d[0].id    = TAG_ID_W'(gnt_idx);
    for (int k = 1; k <= DP_LATENCY; k++)
      tag_d[k] = tag_q[k-1];
    dp_data_d = gnt_any ? bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign last = tag_q[DP_LATENCY];

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++)
      rsp_valid[i] = last.valid && (last.id == TAG_ID_W'(i));
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = last.valid ? dp_data_i : '0;
  assign bus.rsp_bool  = last.valid & dp_bool_i;

  assign busy_o    = !(run && !any_tag);
  assign dp_rstn   = (state_q != DPRST);
  assign dp_data_o = dp_data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= DPRST;
      cnt_q     <= '0;
      tag_q     <= '0;
      dp_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      dp_data_q <= dp_data_d;
    end
  end

endmodule

// File: tb/tb_just_pass_arbiter.sv
// Bench for just_pass_arbiter: directed requests, scoreboard on responses,
// with a one-cycle pass-through datapath stub behind the arbiter.
module tb_just_pass_arbiter;

  logic       clk;
  logic       rstn;
  logic       flush_i;
  logic       busy_o;
  logic       dp_rstn;
  logic [7:0] dp_data_o;
  logic [7:0] dp_data_i;
  logic       dp_bool_i;
  logic [7:0] dp_q;

  just_pass_arbiter_if #(.N_REQ(4), .DATA_WIDTH(8)) bus ();

  just_pass_arbiter #(
    .DATA_WIDTH (8),
    .N_REQ      (4),
    .DP_LATENCY (1),
    .RST_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .flush_i   (flush_i),
    .busy_o    (busy_o),
    .dp_rstn   (dp_rstn),
    .dp_data_o (dp_data_o),
    .dp_data_i (dp_data_i),
    .dp_bool_i (dp_bool_i)
  );

  // Datapath stub: data passes with one cycle latency, bool = nonzero.
  always @(posedge clk or negedge dp_rstn)
    if (!dp_rstn) dp_q <= '0;
    else          dp_q <= dp_data_o;
  assign dp_data_i = dp_q;
  assign dp_bool_i = |dp_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] onehot;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid !== 4'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_stray: got valid=%b data=%h at cycle %0d, none expected",
                 bus.rsp_valid, bus.rsp_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.rsp_valid !== e.onehot || bus.rsp_data !== e.data ||
            bus.rsp_bool !== (e.data != 8'h00) || cyc != e.cyc) begin
          errors++;
          $display("FAIL rsp: got valid=%b data=%h bool=%b cyc=%0d expected valid=%b data=%h bool=%b cyc=%0d",
                   bus.rsp_valid, bus.rsp_data, bus.rsp_bool, cyc,
                   e.onehot, e.data, (e.data != 8'h00), e.cyc);
        end
      end
    end else begin
      chk("rsp_idle_zero", {bus.rsp_bool, bus.rsp_data}, 32'h0);
    end
  end

  task automatic step(input logic [3:0] v, input logic [31:0] d,
                      input logic [3:0] exp_gnt, input string name);
    exp_t e;
    @(posedge clk); #1;
    bus.req_valid = v;
    bus.req_data  = d;
    #1;
    chk(name, bus.req_ready, exp_gnt);
    if (exp_gnt != 4'b0) begin
      e.cyc    = cyc + 2;
      e.onehot = exp_gnt;
      e.data   = 8'h00;
      for (int i = 0; i < 4; i++)
        if (exp_gnt[i]) e.data = d[i*8 +: 8];
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0, 32'h0, 4'b0, "idle_ready");
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready",   bus.req_ready, 4'b0);
    chk("rst_rsp",     {bus.rsp_valid, bus.rsp_bool, bus.rsp_data}, 32'h0);
    chk("rst_dp_rstn", dp_rstn, 1'b0);
    chk("rst_dp_data", dp_data_o, 8'h00);
    chk("rst_busy",    busy_o, 1'b1);
  endtask

  // Release reset while all requesters ask; nothing may be granted before RUN.
  task automatic reset_release();
    @(posedge clk); #1;
    rstn          = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(posedge clk);
      #2;
      chk("seq_dp_rstn", dp_rstn, (k >= 4) ? 1'b1 : 1'b0);
      chk("seq_ready",   bus.req_ready, 4'b0);
      chk("seq_busy",    busy_o, 1'b1);
    end
    bus.req_valid = 4'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          lows;
    rstn          = 1'b0;
    flush_i       = 1'b0;
    bus.req_valid = 4'b0;
    bus.req_data  = 32'h0;

    @(posedge clk); #1;
    chk_reset_vals();
    reset_release();

    // All four valid for 12 cycles: strict rotation from pointer 0.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'(k*16 + i + 1);
      step(4'hF, d, 4'b0001 << (k % 4), "rot_grant");
    end
    idle(3);
    chk("busy_idle", busy_o, 1'b0);

    // Single requester granted every cycle.
    step(4'b0100, 32'h00A5_0000, 4'b0100, "single_grant");
    step(4'b0100, 32'h005A_0000, 4'b0100, "single_grant");
    step(4'b0100, 32'h003C_0000, 4'b0100, "single_grant");
    idle(3);

    // Pointer survives idle cycles: after req 1, req 3 beats req 0.
    step(4'b0010, 32'h0000_7700, 4'b0010, "gap_grant1");
    idle(5);
    step(4'b1001, 32'hC300_0000, 4'b1000, "gap_grant3");
    step(4'b1001, 32'hC300_0000, 4'b0001, "gap_grant0");
    idle(3);

    // Flush with two tags in flight.
    step(4'b0001, 32'h0000_0011, 4'b0001, "fl_grant0");
    step(4'b0010, 32'h0000_2200, 4'b0010, "fl_grant1");
    @(posedge clk); #1;
    bus.req_valid = 4'b0;
    flush_i       = 1'b1;
    #1;
    chk("fl_busy", busy_o, 1'b1);
    lows = 0;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); #1;
      flush_i       = 1'b0;
      bus.req_valid = 4'hF;
      #1;
      chk("fl_ready", bus.req_ready, 4'b0);
      chk("fl_busy",  busy_o, 1'b1);
      if (!dp_rstn) lows++;
    end
    @(posedge clk); #1;
    bus.req_valid = 4'b0;
    #1;
    chk("fl_dp_rstn_cycles", lows, 4);
    chk("fl_busy_done", busy_o, 1'b0);
    idle(2);

    // Async reset mid-burst: in-flight tag must vanish.
    @(posedge clk); #1;
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h4433_2211;
    #1;
    chk("mid_grant", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk); #1;
    reset_release();
    step(4'b0110, 32'h0044_5500, 4'b0010, "post_rst_grant1");
    step(4'b0110, 32'h0044_5500, 4'b0100, "post_rst_grant2");
    idle(3);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
